// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pkg
// Purpose  : 640x480@60 default timing constants and coordinate helpers.
// Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL_DEF = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  localparam int HSYNC_START_DEF = H_DISPLAY_DEF + H_FRONT_DEF;
  localparam int HSYNC_END_DEF   = HSYNC_START_DEF + H_SYNC_DEF - 1;
  localparam int VSYNC_START_DEF = V_DISPLAY_DEF + V_FRONT_DEF;
  localparam int VSYNC_END_DEF   = VSYNC_START_DEF + V_SYNC_DEF - 1;

  localparam int CENTER_X = H_DISPLAY_DEF / 2;
  localparam int CENTER_Y = V_DISPLAY_DEF / 2;

  function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_core_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : mod_counter
// Purpose  : Wrap-around counter exposing its next value and last-count flag.
// Revision : 1.0 - initial release
// ============================================================================
module mod_counter #(
  parameter int MAX = 800,
  parameter int W   = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_value,
  output logic [W-1:0] o_next,
  output logic         o_wrap
);

  // Reset parks on the last count so the first enabled edge lands on zero.
  localparam logic [W-1:0] C_LAST = W'(MAX - 1);

  logic [W-1:0] r_value;

  assign o_wrap  = (r_value == C_LAST);
  assign o_next  = !i_en ? r_value : (o_wrap ? '0 : r_value + 1'b1);
  assign o_value = r_value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= C_LAST;
    end else begin
      r_value <= o_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_timing_core.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_core
// Purpose  : VGA pixel timing: counters, registered sync/blank, strobes, frame count.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_core
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY       = H_DISPLAY_DEF,
  parameter int H_FRONT         = H_FRONT_DEF,
  parameter int H_SYNC          = H_SYNC_DEF,
  parameter int H_BACK          = H_BACK_DEF,
  parameter int V_DISPLAY       = V_DISPLAY_DEF,
  parameter int V_FRONT         = V_FRONT_DEF,
  parameter int V_SYNC          = V_SYNC_DEF,
  parameter int V_BACK          = V_BACK_DEF,
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int FRAME_CNT_W     = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   display_on,
  output logic [COORD_W-1:0]     hpos,
  output logic [COORD_W-1:0]     vpos,
  output logic                   line_start,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
      $error("vga_timing_core: H_TOTAL and V_TOTAL must not exceed 1024");
    end
  endgenerate

  localparam coord_t C_H_DISP   = coord_t'(H_DISPLAY);
  localparam coord_t C_V_DISP   = coord_t'(V_DISPLAY);
  localparam coord_t C_HS_START = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t C_HS_END   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam coord_t C_VS_START = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t C_VS_END   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic   C_SYNC_IDLE = SYNC_ACTIVE_LOW;

  coord_t w_h_next;
  coord_t w_v_next;
  logic   w_h_wrap;
  logic   w_v_wrap;

  mod_counter #(.MAX(H_TOTAL), .W(COORD_W)) u_hcnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (1'b1),
    .o_value (hpos),
    .o_next  (w_h_next),
    .o_wrap  (w_h_wrap)
  );

  mod_counter #(.MAX(V_TOTAL), .W(COORD_W)) u_vcnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_h_wrap),
    .o_value (vpos),
    .o_next  (w_v_next),
    .o_wrap  (w_v_wrap)
  );

  logic                   r_hsync;
  logic                   r_vsync;
  logic                   r_display_on;
  logic                   r_line_start;
  logic                   r_frame_start;
  logic [FRAME_CNT_W-1:0] r_frame_count;

  // Outputs are decoded from the next counter values so they align with hpos/vpos.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync       <= C_SYNC_IDLE;
      r_vsync       <= C_SYNC_IDLE;
      r_display_on  <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_hsync       <= in_range(w_h_next, C_HS_START, C_HS_END) ^ C_SYNC_IDLE;
      r_vsync       <= in_range(w_v_next, C_VS_START, C_VS_END) ^ C_SYNC_IDLE;
      r_display_on  <= (w_h_next < C_H_DISP) && (w_v_next < C_V_DISP);
      r_line_start  <= w_h_wrap;
      r_frame_start <= w_h_wrap && w_v_wrap;
      // Advance on entry to vertical blank so the count never moves on visible pixels.
      if (w_h_wrap && (w_v_next == C_V_DISP)) begin
        r_frame_count <= r_frame_count + 1'b1;
      end
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign display_on  = r_display_on;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_core
// Purpose  : Directed vector bench for vga_timing_core (default, short-V and tiny modes).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // A: default 640x480; B: default horizontal, short vertical; C: tiny mode, active-high sync.
  logic       a_hs, a_vs, a_de, a_ls, a_fs;
  logic [9:0] a_h, a_v, a_fc;
  logic       b_hs, b_vs, b_de, b_ls, b_fs;
  logic [9:0] b_h, b_v, b_fc;
  logic       c_hs, c_vs, c_de, c_ls, c_fs;
  logic [9:0] c_h, c_v;
  logic [2:0] c_fc;

  vga_timing_core u_a (
    .clk(clk), .rst_n(rst_n), .hsync(a_hs), .vsync(a_vs), .display_on(a_de),
    .hpos(a_h), .vpos(a_v), .line_start(a_ls), .frame_start(a_fs), .frame_count(a_fc)
  );

  vga_timing_core #(.V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)) u_b (
    .clk(clk), .rst_n(rst_n), .hsync(b_hs), .vsync(b_vs), .display_on(b_de),
    .hpos(b_h), .vpos(b_v), .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc)
  );

  vga_timing_core #(.H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
                    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                    .SYNC_ACTIVE_LOW(1'b0), .FRAME_CNT_W(3)) u_c (
    .clk(clk), .rst_n(rst_n), .hsync(c_hs), .vsync(c_vs), .display_on(c_de),
    .hpos(c_h), .vpos(c_v), .line_start(c_ls), .frame_start(c_fs), .frame_count(c_fc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int         sel;
    int         cyc;
    logic [9:0] h, v;
    logic       hs, vs, de, ls, fs;
    logic [9:0] fc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int sel, input int cyc, input int h, input int v,
                     input logic hs, input logic vs, input logic de,
                     input logic ls, input logic fs, input int fc);
    vec_t t;
    t.sel = sel; t.cyc = cyc; t.h = 10'(h); t.v = 10'(v);
    t.hs = hs; t.vs = vs; t.de = de; t.ls = ls; t.fs = fs; t.fc = 10'(fc);
    tbl.push_back(t);
  endtask

  task automatic chk_dut(input string tag, input int sel, input logic [9:0] h, input logic [9:0] v,
                         input logic hs, input logic vs, input logic de,
                         input logic ls, input logic fs, input logic [9:0] fc);
    logic [9:0] ah, av, afc;
    logic ahs, avs, ade, als, afs;
    case (sel)
      0:       begin ah = a_h; av = a_v; ahs = a_hs; avs = a_vs; ade = a_de; als = a_ls; afs = a_fs; afc = a_fc; end
      1:       begin ah = b_h; av = b_v; ahs = b_hs; avs = b_vs; ade = b_de; als = b_ls; afs = b_fs; afc = b_fc; end
      default: begin ah = c_h; av = c_v; ahs = c_hs; avs = c_vs; ade = c_de; als = c_ls; afs = c_fs; afc = {7'd0, c_fc}; end
    endcase
    chk({tag, ".hpos"}, ah, h);
    chk({tag, ".vpos"}, av, v);
    chk({tag, ".hsync"}, ahs, hs);
    chk({tag, ".vsync"}, avs, vs);
    chk({tag, ".display_on"}, ade, de);
    chk({tag, ".line_start"}, als, ls);
    chk({tag, ".frame_start"}, afs, fs);
    chk({tag, ".frame_count"}, afc, fc);
  endtask

  // Tiny-mode reference: H_TOTAL=14, V_TOTAL=7, hsync 10..11, vsync line 5, blank from line 4.
  logic sb_en = 1'b0;
  int   mh, mv, mfc;
  always @(negedge clk) begin
    if (!sb_en) begin
      mh = 13; mv = 6; mfc = 0;
    end else begin
      if (mh == 13) begin
        mh = 0;
        mv = (mv == 6) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
      if (mh == 0 && mv == 4) mfc = (mfc + 1) % 8;
      chk_dut("sb_tiny", 2, 10'(mh), 10'(mv), (mh >= 10 && mh <= 11), (mv == 5),
              (mh < 8 && mv < 4), (mh == 0), (mh == 0 && mv == 0), 10'(mfc));
    end
  end

  initial begin
    int cyc;
    int cnt;
    string tag;

    // A: one line of 640x480 (cycle k after release shows hpos k-1 on line 0).
    add(0,   1,   0, 0, 1, 1, 1, 1, 1, 0);
    add(1,   1,   0, 0, 1, 1, 1, 1, 1, 0);
    add(2,   1,   0, 0, 0, 0, 1, 1, 1, 0);
    add(2,  11,  10, 0, 1, 0, 0, 0, 0, 0);
    add(2,  13,  12, 0, 0, 0, 0, 0, 0, 0);
    add(0, 640, 639, 0, 1, 1, 1, 0, 0, 0);
    add(0, 641, 640, 0, 1, 1, 0, 0, 0, 0);
    add(0, 656, 655, 0, 1, 1, 0, 0, 0, 0);
    add(0, 657, 656, 0, 0, 1, 0, 0, 0, 0);
    add(0, 752, 751, 0, 0, 1, 0, 0, 0, 0);
    add(0, 753, 752, 0, 1, 1, 0, 0, 0, 0);
    add(0, 800, 799, 0, 1, 1, 0, 0, 0, 0);
    add(0, 801,   0, 1, 1, 1, 1, 1, 0, 0);
    add(0, 802,   1, 1, 1, 1, 1, 0, 0, 0);
    // B: 800-clock lines, 4 visible lines, vsync on line 5, V_TOTAL 7.
    add(1, 2401,   0, 3, 1, 1, 1, 1, 0, 0);
    add(1, 3200, 799, 3, 1, 1, 0, 0, 0, 0);
    add(1, 3201,   0, 4, 1, 1, 0, 1, 0, 1);
    add(1, 4001,   0, 5, 1, 0, 0, 1, 0, 1);
    add(1, 4657, 656, 5, 0, 0, 0, 0, 0, 1);
    add(1, 4801,   0, 6, 1, 1, 0, 1, 0, 1);
    add(1, 5600, 799, 6, 1, 1, 0, 0, 0, 1);
    add(1, 5601,   0, 0, 1, 1, 1, 1, 1, 1);

    repeat (5) @(posedge clk);
    #1;
    chk_dut("rst_a", 0, 799, 524, 1, 1, 0, 0, 0, 0);
    chk_dut("rst_c", 2, 13, 6, 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    rst_n = 1'b1;
    sb_en = 1'b1;
    cyc   = 0;

    foreach (tbl[i]) begin
      while (cyc < tbl[i].cyc) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      tag = $sformatf("vec%0d", i);
      chk_dut(tag, tbl[i].sel, tbl[i].h, tbl[i].v, tbl[i].hs, tbl[i].vs,
              tbl[i].de, tbl[i].ls, tbl[i].fs, tbl[i].fc);
    end

    // Frame length on B: frame_start strobes exactly 7*800 clocks apart.
    cnt = 0;
    while (!b_fs && cnt < 6000) begin @(posedge clk); #1; cnt++; end
    chk("b_fs_found", b_fs, 1);
    cnt = 0;
    do begin @(posedge clk); #1; cnt++; end while (!b_fs && cnt < 6000);
    chk("b_frame_len", cnt, 5600);

    // Frame length on C: 14*7 clocks.
    cnt = 0;
    while (!c_fs && cnt < 200) begin @(posedge clk); #1; cnt++; end
    cnt = 0;
    do begin @(posedge clk); #1; cnt++; end while (!c_fs && cnt < 200);
    chk("c_frame_len", cnt, 98);
    sb_en = 1'b0;

    // Asynchronous reset mid-line on A at hpos 300.
    cnt = 0;
    while (a_h != 10'd300 && cnt < 1000) begin @(posedge clk); #1; cnt++; end
    chk("a_reach_300", a_h, 300);
    #2;
    rst_n = 1'b0;
    #1;
    chk_dut("async_a", 0, 799, 524, 1, 1, 0, 0, 0, 0);
    chk_dut("async_b", 1, 799, 6, 1, 1, 0, 0, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    chk_dut("hold_a", 0, 799, 524, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_dut("rel_a", 0, 0, 0, 1, 1, 1, 1, 1, 0);
    chk_dut("rel_c", 2, 0, 0, 0, 0, 1, 1, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
